// File: rtl/debug_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_pkg: shared opcodes, FSM encoding and sentinel for the debug unit
// Revision: 1.0
// ------------------------------------------------------------------
package debug_pkg;

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_RUN  = 4'd2;
  localparam logic [3:0] OP_STEP = 4'd3;
  localparam logic [3:0] OP_BRK  = 4'd4;
  localparam logic [3:0] OP_DUMP = 4'd5;

  // Wide enough for any supported NBITS; consumers slice the low bits.
  localparam int unsigned MAX_NBITS = 64;
  localparam logic [MAX_NBITS-1:0] ALL_ONES = '1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_RUN      = 4'd2,
    S_STEP     = 4'd3,
    S_TX_WAIT  = 4'd4,
    S_SEND_PC  = 4'd5,
    S_SEND_DM  = 4'd6,
    S_SEND_RB  = 4'd7,
    S_SEND_CLK = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dbg_tx_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// dbg_tx_seq: registers one outgoing word, pulses tx_start, waits for tx_done
// Revision: 1.0
// ------------------------------------------------------------------
module dbg_tx_seq #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [NBITS-1:0] data_i,
  input  logic             tx_done_i,
  output logic [NBITS-1:0] tx_data_o,
  output logic             tx_start_o,
  output logic             done_o
);

  logic [NBITS-1:0] data_q;
  logic             start_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= load_i;
      if (load_i) begin
        data_q <= data_i;
      end
      busy_q <= load_i | (busy_q & ~tx_done_i);
    end
  end

  assign tx_data_o  = data_q;
  assign tx_start_o = start_q;
  assign done_o     = busy_q & tx_done_i;

endmodule
`default_nettype wire

// File: rtl/debug_cmd_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_cmd_controller: host-driven program load, run/step/breakpoint, state dump
// Revision: 1.0
// ------------------------------------------------------------------
module debug_cmd_controller
  import debug_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int IM_MEM_SIZE = 5,
  parameter int DM_MEM_SIZE = 2,
  parameter int BANK_SIZE   = 5,
  parameter int RBITS       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] rx_Data,
  input  logic             rx_done,
  output logic [NBITS-1:0] tx_Data,
  output logic             tx_start,
  input  logic             tx_done,
  output logic [NBITS-1:0] IM_Addr,
  output logic [NBITS-1:0] IM_Data,
  output logic             IM_We,
  output logic [NBITS-1:0] DM_Addr,
  input  logic [NBITS-1:0] DM_Data,
  output logic [RBITS-1:0] RB_Addr,
  input  logic [NBITS-1:0] RB_Data,
  input  logic [NBITS-1:0] current_PC,
  input  logic [NBITS-1:0] clock_count,
  input  logic             halt_flag,
  output logic             clock_enable,
  output logic             o_rst
);

  localparam logic [NBITS-1:0] IM_LAST  = NBITS'(2**IM_MEM_SIZE - 1);
  localparam logic [NBITS-1:0] DM_LAST  = NBITS'(2**DM_MEM_SIZE - 1);
  localparam logic [NBITS-1:0] RB_LAST  = NBITS'(2**BANK_SIZE - 1);
  localparam logic [NBITS-1:0] SENTINEL = ALL_ONES[NBITS-1:0];

  state_t           state_q, state_d, ret_q, ret_d;
  logic [NBITS-1:0] im_addr_q, im_addr_d, im_data_q, im_data_d;
  logic             im_we_q, im_we_d;
  logic [NBITS-1:0] dm_addr_q, dm_addr_d, rb_addr_q, rb_addr_d;
  logic             ce_q, ce_d, o_rst_q, o_rst_d;
  logic [NBITS-1:0] bp_q, bp_d, step_q, step_d;
  logic             bp_valid_q, bp_valid_d, first_q, first_d;

  logic [3:0]       op;
  logic [NBITS-5:0] arg;
  logic [NBITS-1:0] wr_addr, tx_src;
  logic             stop, tx_load, tx_ack;

  assign op  = rx_Data[NBITS-1 -: 4];
  assign arg = rx_Data[NBITS-5:0];
  // A write still pending in IM_We lands before the next one, so account for it.
  assign wr_addr = im_we_q ? im_addr_q + 1'b1 : im_addr_q;
  // The first enabled cycle ignores the breakpoint so execution can leave it.
  assign stop = halt_flag | (bp_valid_q & ~first_q & (current_PC == bp_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      im_addr_q  <= '0;
      im_data_q  <= '0;
      im_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      rb_addr_q  <= '0;
      ce_q       <= 1'b0;
      o_rst_q    <= 1'b1;
      bp_q       <= '0;
      bp_valid_q <= 1'b0;
      step_q     <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      im_addr_q  <= im_addr_d;
      im_data_q  <= im_data_d;
      im_we_q    <= im_we_d;
      dm_addr_q  <= dm_addr_d;
      rb_addr_q  <= rb_addr_d;
      ce_q       <= ce_d;
      o_rst_q    <= o_rst_d;
      bp_q       <= bp_d;
      bp_valid_q <= bp_valid_d;
      step_q     <= step_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    im_addr_d  = wr_addr;
    im_data_d  = im_data_q;
    im_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    rb_addr_d  = rb_addr_q;
    ce_d       = ce_q;
    bp_d       = bp_q;
    bp_valid_d = bp_valid_q;
    step_d     = step_q;
    first_d    = 1'b0;
    tx_load    = 1'b0;
    tx_src     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          case (op)
            OP_LOAD: begin
              state_d   = S_LOAD;
              im_addr_d = '0;
            end
            OP_RUN: begin
              state_d = S_RUN;
              ce_d    = 1'b1;
              first_d = 1'b1;
            end
            OP_STEP: begin
              state_d = S_STEP;
              ce_d    = 1'b1;
              first_d = 1'b1;
              step_d  = (arg == '0) ? NBITS'(1) : NBITS'(arg);
            end
            OP_BRK: begin
              bp_valid_d = ~(&arg);
              bp_d       = NBITS'(arg);
            end
            OP_DUMP: state_d = S_SEND_PC;
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (rx_done) begin
          im_we_d   = 1'b1;
          im_data_d = rx_Data;
          if (rx_Data == SENTINEL || wr_addr == IM_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          ce_d    = 1'b0;
          state_d = S_SEND_PC;
        end
      end
      S_STEP: begin
        if (stop || step_q == NBITS'(1)) begin
          ce_d    = 1'b0;
          step_d  = '0;
          state_d = S_SEND_PC;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      S_SEND_PC, S_SEND_DM, S_SEND_RB, S_SEND_CLK: begin
        tx_load = 1'b1;
        ret_d   = state_q;
        state_d = S_TX_WAIT;
        case (state_q)
          S_SEND_PC: tx_src = current_PC;
          S_SEND_DM: tx_src = DM_Data;
          S_SEND_RB: tx_src = RB_Data;
          default:   tx_src = clock_count;
        endcase
      end
      S_TX_WAIT: begin
        if (tx_ack) begin
          case (ret_q)
            S_SEND_PC: begin
              dm_addr_d = '0;
              state_d   = S_SEND_DM;
            end
            S_SEND_DM: begin
              if (dm_addr_q == DM_LAST) begin
                rb_addr_d = '0;
                state_d   = S_SEND_RB;
              end else begin
                dm_addr_d = dm_addr_q + 1'b1;
                state_d   = S_SEND_DM;
              end
            end
            S_SEND_RB: begin
              if (rb_addr_q == RB_LAST) begin
                state_d = S_SEND_CLK;
              end else begin
                rb_addr_d = rb_addr_q + 1'b1;
                state_d   = S_SEND_RB;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    o_rst_d = (state_d == S_LOAD);
  end

  dbg_tx_seq #(.NBITS(NBITS)) u_tx_seq (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tx_load),
    .data_i     (tx_src),
    .tx_done_i  (tx_done),
    .tx_data_o  (tx_Data),
    .tx_start_o (tx_start),
    .done_o     (tx_ack)
  );

  assign IM_Addr      = im_addr_q;
  assign IM_Data      = im_data_q;
  assign IM_We        = im_we_q;
  assign DM_Addr      = dm_addr_q;
  assign RB_Addr      = rb_addr_q[RBITS-1:0];
  assign clock_enable = ce_q;
  assign o_rst        = o_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_debug_cmd_controller: directed self-checking bench for debug_cmd_controller
// Revision: 1.0
// ------------------------------------------------------------------
module tb_debug_cmd_controller;

  localparam logic [31:0] CC_VAL = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_Data;
  logic        rx_done;
  logic [31:0] tx_Data;
  logic        tx_start;
  logic        tx_done;
  logic [31:0] IM_Addr, IM_Data, DM_Addr, DM_Data, RB_Data;
  logic        IM_We;
  logic [4:0]  RB_Addr;
  logic [31:0] current_PC, clock_count;
  logic        halt_flag, clock_enable, o_rst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory/register file stand-ins: contents encode their own address.
  assign DM_Data = 32'hD000_0000 | DM_Addr;
  assign RB_Data = 32'hB000_0000 | {27'd0, RB_Addr};

  debug_cmd_controller dut (
    .clk          (clk),
    .reset        (reset),
    .rx_Data      (rx_Data),
    .rx_done      (rx_done),
    .tx_Data      (tx_Data),
    .tx_start     (tx_start),
    .tx_done      (tx_done),
    .IM_Addr      (IM_Addr),
    .IM_Data      (IM_Data),
    .IM_We        (IM_We),
    .DM_Addr      (DM_Addr),
    .DM_Data      (DM_Data),
    .RB_Addr      (RB_Addr),
    .RB_Data      (RB_Data),
    .current_PC   (current_PC),
    .clock_count  (clock_count),
    .halt_flag    (halt_flag),
    .clock_enable (clock_enable),
    .o_rst        (o_rst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] w);
    rx_Data = w;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_Data = '0;
  endtask

  task automatic get_word(output logic [31:0] w);
    int k = 0;
    while (tx_start !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("tx_start_seen", {31'd0, tx_start}, 32'd1);
    w = tx_Data;
    tick();
    chk("tx_start_one_cycle", {31'd0, tx_start}, 32'd0);
    chk("tx_data_hold", tx_Data, w);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_dump(input logic [31:0] pc_exp, input string tag);
    logic [31:0] w;
    get_word(w);
    chk({tag, "_pc"}, w, pc_exp);
    for (int k = 0; k < 4; k++) begin
      get_word(w);
      chk({tag, "_dm"}, w, 32'hD000_0000 + 32'(k));
    end
    for (int k = 0; k < 32; k++) begin
      get_word(w);
      chk({tag, "_rb"}, w, 32'hB000_0000 + 32'(k));
    end
    get_word(w);
    chk({tag, "_clk"}, w, CC_VAL);
    tick();
    chk({tag, "_no_extra_start"}, {31'd0, tx_start}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    bit ok;
    reset = 1'b1; rx_Data = '0; rx_done = 1'b0; tx_done = 1'b0;
    current_PC = 32'h0; clock_count = CC_VAL; halt_flag = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_im_addr", IM_Addr, 32'd0);
    chk("rst_im_we", {31'd0, IM_We}, 32'd0);
    chk("rst_im_data", IM_Data, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", tx_Data, 32'd0);
    chk("rst_ce", {31'd0, clock_enable}, 32'd0);
    chk("rst_o_rst", {31'd0, o_rst}, 32'd1);
    reset = 1'b0;
    tick();
    chk("idle_o_rst_low", {31'd0, o_rst}, 32'd0);

    // LOAD with sentinel
    send_cmd(32'h1000_0000);
    chk("load_o_rst", {31'd0, o_rst}, 32'd1);
    chk("load_addr_clear", IM_Addr, 32'd0);
    send_cmd(32'h0000_00FF);
    chk("load0_we", {31'd0, IM_We}, 32'd1);
    chk("load0_addr", IM_Addr, 32'd0);
    chk("load0_data", IM_Data, 32'h0000_00FF);
    tick();
    chk("load0_we_pulse", {31'd0, IM_We}, 32'd0);
    send_cmd(32'h0000_000F);
    chk("load1_addr", IM_Addr, 32'd1);
    chk("load1_data", IM_Data, 32'h0000_000F);
    tick();
    send_cmd(32'hFFFF_FFFF);
    chk("load2_we", {31'd0, IM_We}, 32'd1);
    chk("load2_addr", IM_Addr, 32'd2);
    chk("load2_data", IM_Data, 32'hFFFF_FFFF);
    chk("load_exit_o_rst", {31'd0, o_rst}, 32'd0);
    tick();
    send_cmd(32'h0000_0055);
    chk("idle_ignores_word", {31'd0, IM_We}, 32'd0);

    // LOAD 32 words, no sentinel
    tick();
    send_cmd(32'h1000_0000);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send_cmd(32'hA000_0000 + 32'(i));
      if (IM_We !== 1'b1 || IM_Addr !== 32'(i)) ok = 1'b0;
      tick();
    end
    chk("load32_all_writes", {31'd0, ok}, 32'd1);
    chk("load32_exit_o_rst", {31'd0, o_rst}, 32'd0);
    chk("load32_final_addr", IM_Addr, 32'd32);
    send_cmd(32'h0000_0077);
    chk("load32_idle", {31'd0, IM_We}, 32'd0);

    // STEP 3 then full dump
    current_PC = 32'h40;
    send_cmd(32'h3000_0003);
    n = 0;
    while (clock_enable === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("step3_cycles", 32'(n), 32'd3);
    run_dump(32'h40, "step3");

    // Breakpoint hit during RUN
    send_cmd(32'h4000_0010);
    current_PC = 32'h08;
    send_cmd(32'h2000_0000);
    chk("run_ce_on", {31'd0, clock_enable}, 32'd1);
    tick();
    chk("run_ce_still_on", {31'd0, clock_enable}, 32'd1);
    current_PC = 32'h10;
    tick();
    chk("bp_ce_drop", {31'd0, clock_enable}, 32'd0);
    run_dump(32'h10, "bp");

    // Breakpoint on first cycle is passed, then halt with tx_done withheld
    send_cmd(32'h2000_0000);
    tick();
    chk("bp_first_cycle_granted", {31'd0, clock_enable}, 32'd1);
    current_PC = 32'h14;
    tick();
    halt_flag = 1'b1;
    tick();
    chk("halt_ce_drop", {31'd0, clock_enable}, 32'd0);
    halt_flag = 1'b0;
    tick();
    chk("halt_tx_start", {31'd0, tx_start}, 32'd1);
    chk("halt_tx_pc", tx_Data, 32'h14);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_start === 1'b1) n++;
      if (tx_Data !== 32'h14) n += 100;
    end
    chk("withheld_no_restart_hold", 32'(n), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    get_word(w);
    chk("halt_dm0", w, 32'hD000_0000);
    chk("dm_addr_advanced", DM_Addr, 32'd1);

    // Reset during SEND_DM
    reset = 1'b1;
    tick();
    chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("midrst_tx_data", tx_Data, 32'd0);
    chk("midrst_dm_addr", DM_Addr, 32'd0);
    chk("midrst_im_addr", IM_Addr, 32'd0);
    chk("midrst_ce", {31'd0, clock_enable}, 32'd0);
    chk("midrst_o_rst", {31'd0, o_rst}, 32'd1);
    reset = 1'b0;
    tick(); tick();
    chk("postrst_no_start", {31'd0, tx_start}, 32'd0);
    chk("postrst_o_rst", {31'd0, o_rst}, 32'd0);

    // STEP with arg 0 behaves as a single step
    current_PC = 32'h80;
    send_cmd(32'h3000_0000);
    n = 0;
    while (clock_enable === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("step0_cycles", 32'(n), 32'd1);
    run_dump(32'h80, "step0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_cmd_controller.md
DEBUG_CMD_CONTROLLER -- requirements
Module: debug_cmd_controller

Interface
REQ-001 SHALL have parameters (name, default, meaning): NBITS 32, data/command word width; IM_MEM_SIZE 5, log2 instruction-memory depth; DM_MEM_SIZE 2, log2 dumped data-memory words; BANK_SIZE 5, log2 register count; RBITS 5, register address width.
REQ-002 SHALL use one clock `clk`; `reset` is synchronous and active-high.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- rx_Data  in  NBITS  received word
- rx_done  in  1  rx_Data valid, one-cycle pulse
- tx_Data  out  NBITS  word to transmit
- tx_start  out  1  transmit request pulse
- tx_done  in  1  transmitter finished, one-cycle pulse
- IM_Addr  out  NBITS  instruction write address
- IM_Data  out  NBITS  instruction write data
- IM_We  out  1  instruction write enable
- DM_Addr  out  NBITS  data-memory read address
- DM_Data  in  NBITS  data-memory read data, combinational
- RB_Addr  out  RBITS  register read address
- RB_Data  in  NBITS  register read data, combinational
- current_PC  in  NBITS  CPU program counter
- clock_count  in  NBITS  CPU cycle counter
- halt_flag  in  1  CPU halt retired
- clock_enable  out  1  CPU clock gate
- o_rst  out  1  CPU reset

Function
REQ-004 SHALL decode a command word in IDLE as opcode = rx_Data[NBITS-1:NBITS-4] and arg = remaining bits; opcodes: 1 LOAD, 2 RUN, 3 STEP, 4 BRK, 5 DUMP; all other opcodes are ignored, and the block stays in IDLE.
REQ-005 SHALL use states IDLE, LOAD, RUN, STEP, TX_WAIT, SEND_PC, SEND_DM, SEND_RB, SEND_CLK.
REQ-006 LOAD: o_rst SHALL be high for the whole state.
- Each rx_done SHALL cause a one-cycle IM_We with IM_Data = rx_Data at IM_Addr, followed by an IM_Addr increment.
- A word equal to all-ones SHALL be written, and the state then returns to IDLE.
- A write at IM_Addr = 2^IM_MEM_SIZE-1 SHALL also return the state to IDLE.
- IM_Addr SHALL clear on entry to LOAD.
REQ-007 RUN: clock_enable SHALL be high until halt_flag=1 or current_PC equals the armed breakpoint; clock_enable SHALL drop on the next edge, and the state then goes to SEND_PC.
REQ-008 STEP: a step counter SHALL load arg, with arg=0 treated as 1.
- clock_enable SHALL be high for exactly that many cycles, and the state then goes to SEND_PC.
- halt_flag or a breakpoint match SHALL end the step early.
REQ-009 BRK SHALL arm breakpoint = arg zero-extended; arg all-ones SHALL disarm it; the state returns to IDLE the next cycle.
REQ-010 DUMP SHALL go directly to SEND_PC without running the CPU.
REQ-011 The dump order SHALL be: current_PC; then DM_Data for DM_Addr 0..2^DM_MEM_SIZE-1; then RB_Data for RB_Addr 0..2^BANK_SIZE-1; then clock_count; then return to IDLE.
REQ-012 Each dumped word SHALL be driven as follows:
- tx_Data SHALL be registered from the source while tx_start pulses high for one cycle.
- The state SHALL then wait in TX_WAIT for tx_done before advancing.
- tx_Data SHALL hold stable until tx_done.
REQ-013 rx_done SHALL be ignored outside IDLE and LOAD; tx_done SHALL be ignored outside TX_WAIT.
REQ-014 A breakpoint matching current_PC on the first RUN/STEP cycle SHALL still grant one enabled cycle, so the CPU advances past the breakpoint.
REQ-015 The address counters SHALL be NBITS wide with no wrap; their terminal counts come from the parameters.

Reset
REQ-016 reset SHALL force state IDLE, with the following values:
- IM_Addr=0, IM_Data=0, IM_We=0
- DM_Addr=0, RB_Addr=0
- tx_Data=0, tx_start=0
- clock_enable=0, o_rst=1
- breakpoint disarmed, step counter 0
REQ-017 Reset asserted mid-LOAD, mid-RUN or mid-dump SHALL abort the operation on the same edge with no further IM_We or tx_start.
REQ-018 o_rst SHALL deassert when IDLE is entered after reset and stay low except during LOAD.

Structure
REQ-019 Opcode constants, state encodings and the all-ones sentinel SHALL live in a shared package, debug_pkg.
REQ-020 The tx_start/tx_done handshake SHALL be one sub-module, dbg_tx_seq, reused for every dumped word.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- LOAD, then 0xFF, 0x0F, 0xFFFFFFFF -> IM_We three times at IM_Addr 0,1,2, then IDLE.
- LOAD, then 32 words without the sentinel -> writes stop at IM_Addr 31, then IDLE.
- STEP arg=3 -> clock_enable high exactly 3 cycles, then 1+4+32+1 = 38 tx_start pulses in the REQ-011 order.
- BRK 0x10, RUN, current_PC=0x10 -> clock_enable drops the next edge, and the dump starts with tx_Data=0x10.
- RUN, halt_flag=1 with tx_done withheld -> a single tx_start, held until tx_done.
- reset during SEND_DM -> all outputs at reset values the next cycle.
